// File: rtl/mux_2to1.sv
// One-bit 2:1 multiplexer with a combinational result, a registered copy of it,
// and a saturating counter of clock edges on which the select differs from its last sampled value.
module mux_2to1 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       data,
    input  logic             sel,
    output logic             out,
    output logic             out_q,
    output logic [CNT_W-1:0] sel_changes
);

    logic             sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The mux never looks at clk or rst, so it keeps working during reset or without a clock.
    assign out = sel ? data[1] : data[0];

    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if ((sel != sel_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 1'b0;
            sel_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            out_q <= out;
            sel_q <= sel;
            cnt_q <= cnt_d;
        end
    end

    assign sel_changes = cnt_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: directed steps plus a randomized run, compared
// against a counting reference model for both an 8-bit and a 3-bit counter instance.
`timescale 1ns/1ps
module tb_mux_2to1;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic [1:0] data;
    logic       sel;

    logic       out8, out_q8;
    logic [7:0] cnt8;
    logic       out3, out_q3;
    logic [2:0] cnt3;

    int checks;
    int errors;

    // Reference model: last sampled select, plain integer counts clamped at their ceiling.
    int ref_prev_sel;
    int ref_cnt8;
    int ref_cnt3;
    int ref_out_q;

    mux_2to1 #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .data(data), .sel(sel),
        .out(out8), .out_q(out_q8), .sel_changes(cnt8)
    );

    mux_2to1 #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .data(data), .sel(sel),
        .out(out3), .out_q(out_q3), .sel_changes(cnt3)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mux_ref(input logic [1:0] d, input logic s);
        int idx;
        idx = s ? 1 : 0;
        return int'(d[idx]);
    endfunction

    task automatic model_reset();
        ref_prev_sel = 0;
        ref_cnt8     = 0;
        ref_cnt3     = 0;
        ref_out_q    = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out8"},  32'(out8),   32'(mux_ref(data, sel)));
        check({tag, ".out3"},  32'(out3),   32'(mux_ref(data, sel)));
        check({tag, ".outq8"}, 32'(out_q8), 32'(ref_out_q));
        check({tag, ".outq3"}, 32'(out_q3), 32'(ref_out_q));
        check({tag, ".cnt8"},  32'(cnt8),   32'(ref_cnt8));
        check({tag, ".cnt3"},  32'(cnt3),   32'(ref_cnt3));
    endtask

    // One rising edge: update the model from the inputs present at the edge, then sample.
    task automatic tick();
        int s;
        @(posedge clk);
        s = sel ? 1 : 0;
        if (!rst) begin
            if (s != ref_prev_sel) begin
                ref_cnt8 = (ref_cnt8 + 1 > 255) ? 255 : ref_cnt8 + 1;
                ref_cnt3 = (ref_cnt3 + 1 > 7) ? 7 : ref_cnt3 + 1;
            end
            ref_prev_sel = s;
            ref_out_q    = mux_ref(data, sel);
        end
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        model_reset();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clk_run = 1'b0;
        rst     = 1'b1;
        data    = 2'b00;
        sel     = 1'b0;
        model_reset();
        #1;

        // Reset state and exhaustive combinational select with rst held, no clock.
        check("reset.outq8", 32'(out_q8), 32'd0);
        check("reset.cnt8",  32'(cnt8),   32'd0);
        check("reset.cnt3",  32'(cnt3),   32'd0);
        for (int i = 0; i < 8; i++) begin
            data = i[2:1];
            sel  = i[0];
            #10;
            check("exh_rst.out", 32'(out8), 32'(mux_ref(data, sel)));
        end

        // Directed combinational cases with reset released, still no clock.
        rst = 1'b0;
        data = 2'b10; sel = 1'b0; #10; check("comb.10s0", 32'(out8), 32'd0);
        data = 2'b01; sel = 1'b1; #10; check("comb.01s1", 32'(out8), 32'd0);
        data = 2'b01; sel = 1'b0; #10; check("comb.01s0", 32'(out8), 32'd1);
        data = 2'b10; sel = 1'b1; #10; check("comb.10s1", 32'(out8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            data = i[2:1];
            sel  = i[0];
            #10;
            check("exh.out", 32'(out3), 32'(mux_ref(data, sel)));
        end
        check("noclk.cnt8", 32'(cnt8), 32'd0);

        // Registered path.
        clk_run = 1'b1;
        data = 2'b10; sel = 1'b1;
        tick();
        check("regpath.outq", 32'(out_q8), 32'd1);
        check_all("regpath1");
        sel = 1'b0;
        #1;
        check("regpath.out_now", 32'(out8), 32'd0);
        check("regpath.outq_hold", 32'(out_q8), 32'd1);
        tick();
        check("regpath.outq_next", 32'(out_q8), 32'd0);

        // Counter: five toggles from reset starting with sel=1.
        pulse_reset();
        check_all("cnt.afterreset");
        for (int i = 0; i < 5; i++) begin
            sel = (i % 2 == 0);
            tick();
        end
        check("cnt.five8", 32'(cnt8), 32'd5);
        check("cnt.five3", 32'(cnt3), 32'd5);
        for (int i = 0; i < 10; i++) begin
            data = 2'($urandom_range(0, 3));
            tick();
            check_all("cnt.datatoggle");
        end
        check("cnt.hold5", 32'(cnt8), 32'd5);

        // Saturation of the 3-bit counter.
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            sel = (i % 2 == 0);
            tick();
            check_all("sat.step");
        end
        check("sat.cnt3", 32'(cnt3), 32'd7);
        check("sat.cnt8", 32'(cnt8), 32'd10);
        for (int i = 0; i < 3; i++) begin
            sel = ~sel;
            tick();
        end
        check("sat.cnt3_hold", 32'(cnt3), 32'd7);

        // Asynchronous reset between edges, held across an edge.
        pulse_reset();
        data = 2'b10;
        for (int i = 0; i < 5; i++) begin
            sel = (i % 2 == 0);
            tick();
        end
        check("async.pre_cnt", 32'(cnt8), 32'd5);
        check("async.pre_outq", 32'(out_q8), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("async.cnt_clr", 32'(cnt8), 32'd0);
        check("async.outq_clr", 32'(out_q8), 32'd0);
        check("async.out_keep", 32'(out8), 32'd1);
        tick();
        check_all("async.held");
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        tick();
        check("async.first", 32'(cnt8), 32'd1);

        // Randomized run with occasional asynchronous reset pulses.
        for (int i = 0; i < 300; i++) begin
            data = 2'($urandom_range(0, 3));
            sel  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) pulse_reset();
            tick();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
